cmos_pattern_gen: RTL

- Parametrised DVP-style camera stimulus source. It drives byte-serial RGB565 pixels with cmos_href/cmos_vsyn framing, so the SDRAM capture and VGA display path can be exercised without a sensor.
- Successor to the fixed 640x480 bar generator. Adds configurable geometry and timing, four selectable patterns, start/stop control, a frame counter and an end-of-frame pulse.
- Sits in place of the camera at the capture front end; simulation and on-board self-test.

---
 rtl/cmos_gen_pkg.sv | 31 +++
 rtl/cmos_pattern_gen_if.sv | 13 +
 rtl/cmos_pattern_pix.sv | 34 +++
 rtl/cmos_pattern_gen.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/cmos_gen_pkg.sv
// Shared types and constants for the DVP camera stimulus source.
// State and pattern encodings plus RGB565 colour constants.
package cmos_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_V_FRONT,
        ST_H_BLANK,
        ST_ACTIVE,
        ST_V_BACK
    } state_e;

    typedef enum logic [1:0] {
        PAT_BARS,
        PAT_GRAD,
        PAT_CHECK,
        PAT_SOLID
    } pattern_e;

    localparam logic [15:0] RED   = 16'hF800;
    localparam logic [15:0] GREEN = 16'h07E0;
    localparam logic [15:0] BLUE  = 16'h001F;
    localparam logic [15:0] WHITE = 16'hFFFF;
    localparam logic [15:0] BLACK = 16'h0000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cmos_pattern_gen_if.sv
// Byte-serial DVP camera bus plus frame status, as seen by the capture path.
interface cmos_pattern_gen_if;

    logic [7:0]  cmos_data;
    logic        cmos_href;
    logic        cmos_vsyn;
    logic [15:0] frame_cnt;
    logic        frame_done;

    modport master (output cmos_data, cmos_href, cmos_vsyn, frame_cnt, frame_done);
    modport slave  (input  cmos_data, cmos_href, cmos_vsyn, frame_cnt, frame_done);

endinterface

// File: rtl/cmos_pattern_pix.sv
// Combinational pixel source: maps (x, y, pattern, frame tag) to one RGB565 pixel.
// Optional CMOS_LINE_TAG_EN replaces pixel 0 of each line with the line number.
module cmos_pattern_pix
    import cmos_gen_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int X_W      = 10,
    parameter int Y_W      = 9
) (
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  pattern_e       pattern,
    input  logic [15:0]    frame_tag,
    output logic [15:0]    pix
);

    localparam logic [15:0] BAR_W = 16'(H_ACTIVE / 16);

    always_comb begin
        // NOTE: every output gets a value on every path, so no latch is inferred.
        pix = BLACK;
        unique case (pattern)
            PAT_BARS:  pix = 16'h8000 >> (16'(x) / BAR_W);
            PAT_GRAD:  pix = ((16'(x) & 16'h001F) << 11) | ((16'(x) & 16'h003F) << 5)
                           | (16'(x) & 16'h001F);
            PAT_CHECK: pix = (((16'(x) ^ 16'(y)) & 16'h0020) != 16'h0) ? WHITE : BLACK;
            PAT_SOLID: pix = frame_tag;
        endcase
`ifdef CMOS_LINE_TAG_EN
        if (x == '0) pix = 16'(y);
`endif
    end

endmodule

// File: rtl/cmos_pattern_gen.sv
// DVP camera stimulus source: frame timing FSM and RGB565 byte serialiser.
// Optional feature macro CMOS_LINE_TAG_EN (line-number tag on pixel 0, see cmos_pattern_pix).
module cmos_pattern_gen
    import cmos_gen_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int H_BLANK   = 100,
    parameter int VSYNC_LEN = 1000,
    parameter int V_FRONT   = 100,
    parameter int V_BACK    = 100
) (
    input  logic               cmos_pclk,
    input  logic               rst_n,
    input  logic               gen_en,
    input  logic [1:0]         pattern_sel,
    cmos_pattern_gen_if.master dvp
);

    localparam int X_W     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int Y_W     = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int CNT_MAX = max2(max2(VSYNC_LEN, V_FRONT),
                                  max2(max2(V_BACK, H_BLANK), 2 * H_ACTIVE));
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] VSYNC_LAST = CNT_W'(VSYNC_LEN - 1);
    localparam logic [CNT_W-1:0] FRONT_LAST = CNT_W'(V_FRONT - 1);
    localparam logic [CNT_W-1:0] HBLK_LAST  = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0] LINE_LAST  = CNT_W'(2 * H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] BACK_LAST  = CNT_W'(V_BACK - 1);
    localparam logic [Y_W-1:0]   Y_LAST     = Y_W'(V_ACTIVE - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [Y_W-1:0]   y_q, y_d;
    pattern_e         pat_q, pat_d;
    logic [15:0]      tag_q, tag_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             frame_done_q, frame_done_d;
    logic             href_q, href_d;
    logic             vsyn_q, vsyn_d;
    logic [7:0]       data_q, data_d;
    logic [X_W-1:0]   x_d;
    logic [15:0]      pix;

    // Outputs are precomputed from the next state so they line up with it after the edge.
    assign x_d = cnt_d[X_W:1];

    cmos_pattern_pix #(
        .H_ACTIVE (H_ACTIVE),
        .X_W      (X_W),
        .Y_W      (Y_W)
    ) u_pix (
        .x         (x_d),
        .y         (y_d),
        .pattern   (pat_d),
        .frame_tag (tag_d),
        .pix       (pix)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        y_d         = y_q;
        pat_d       = pat_q;
        tag_d       = tag_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (gen_en) begin
                    state_d = ST_VSYNC;
                    pat_d   = pattern_e'(pattern_sel);
                    tag_d   = frame_cnt_q;
                end
            end
            ST_VSYNC: if (cnt_q == VSYNC_LAST) begin
                state_d = ST_V_FRONT;
                cnt_d   = '0;
            end
            ST_V_FRONT: if (cnt_q == FRONT_LAST) begin
                state_d = ST_H_BLANK;
                cnt_d   = '0;
                y_d     = '0;
            end
            ST_H_BLANK: if (cnt_q == HBLK_LAST) begin
                state_d = ST_ACTIVE;
                cnt_d   = '0;
            end
            ST_ACTIVE: if (cnt_q == LINE_LAST) begin
                cnt_d = '0;
                if (y_q == Y_LAST) begin
                    state_d = ST_V_BACK;
                end else begin
                    state_d = ST_H_BLANK;
                    y_d     = y_q + 1'b1;
                end
            end
            ST_V_BACK: if (cnt_q == BACK_LAST) begin
                cnt_d = '0;
                if (gen_en) begin
                    state_d = ST_VSYNC;
                    pat_d   = pattern_e'(pattern_sel);
                    tag_d   = frame_cnt_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The frame counter steps on the edge that enters the last back-porch cycle.
        frame_done_d = (state_d == ST_V_BACK) && (cnt_d == BACK_LAST);
        if (frame_done_d) frame_cnt_d = frame_cnt_q + 16'd1;

        href_d = (state_d == ST_ACTIVE);
        vsyn_d = (state_d == ST_VSYNC);
        data_d = href_d ? (cnt_d[0] ? pix[7:0] : pix[15:8]) : 8'h00;
    end

    always_ff @(posedge cmos_pclk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            y_q          <= '0;
            pat_q        <= PAT_BARS;
            tag_q        <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            href_q       <= 1'b0;
            vsyn_q       <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            y_q          <= y_d;
            pat_q        <= pat_d;
            tag_q        <= tag_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
            href_q       <= href_d;
            vsyn_q       <= vsyn_d;
            data_q       <= data_d;
        end
    end

    assign dvp.cmos_data  = data_q;
    assign dvp.cmos_href  = href_q;
    assign dvp.cmos_vsyn  = vsyn_q;
    assign dvp.frame_cnt  = frame_cnt_q;
    assign dvp.frame_done = frame_done_q;

endmodule
